// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the MEM pipeline stage.
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD)
//   - stage state enum (IDLE / BUSY)
//   - big-endian byte-enable constants (bit3 = bits 31:24)
//   - helpers for misalignment detection, lane enables and store replication
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [3:0] BE_BYTE_MSB = 4'b1000;
  localparam logic [3:0] BE_HALF_HI  = 4'b1100;
  localparam logic [3:0] BE_HALF_LO  = 4'b0011;
  localparam logic [3:0] BE_WORD     = 4'b1111;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: byte_enables = BE_BYTE_MSB >> off;
      SZ_HALF: byte_enables = off[1] ? BE_HALF_LO : BE_HALF_HI;
      default: byte_enables = BE_WORD;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] pb);
    case (size)
      SZ_BYTE: store_data = {4{pb[7:0]}};
      SZ_HALF: store_data = {2{pb[15:0]}};
      default: store_data = pb;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align: combinational big-endian load lane extraction and extension.
// Ports:
//   rdata      in  32  word read from data memory
//   offset     in  2   byte offset within the word (addr[1:0])
//   size       in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   mem_signed in  1   1 = sign-extend, 0 = zero-extend
//   wb_value   out 32  aligned, extended value for write-back
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        mem_signed,
  output logic [31:0] wb_value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    // offset 0 addresses the most significant byte
    case (offset)
      2'd0:    byte_lane = rdata[31:24];
      2'd1:    byte_lane = rdata[23:16];
      2'd2:    byte_lane = rdata[15:8];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = offset[1] ? rdata[15:0] : rdata[31:16];

    case (size)
      SZ_BYTE: wb_value = {{24{mem_signed & byte_lane[7]}}, byte_lane};
      SZ_HALF: wb_value = {{16{mem_signed & half_lane[15]}}, half_lane};
      default: wb_value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage and MEM/WB register.
// Issues data-memory loads/stores over a req/ack bus, stalls upstream while
// an access is outstanding and registers the write-back values.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses that receive no
// dmem_ack within TIMEOUT_CYCLES BUSY cycles (bus_err pulse); otherwise BUSY
// waits indefinitely and bus_err is tied 0.
// Ports:
//   clk, reset (async, active-low)
//   in_valid, mem_read, mem_write, mem_size, mem_signed, reg_write,
//   alu_result, PB, destination             : from EX/MEM
//   stall_out                               : hold EX/MEM and upstream
//   dmem_req/we/addr/be/wdata, dmem_ack/rdata : data-memory bus
//   out_valid, wb_data, destination_out, reg_write_out : to WB
//   align_err, bus_err                      : one-cycle error pulses
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic        reg_write,
  input  logic [31:0] alu_result,
  input  logic [31:0] PB,
  input  logic [4:0]  destination,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  destination_out,
  output logic        reg_write_out,
  output logic        align_err,
  output logic        bus_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e      state, state_d;

  // access context captured on BUSY entry
  logic [1:0]  lat_off,  lat_off_d;
  logic [1:0]  lat_size, lat_size_d;
  logic        lat_signed, lat_signed_d;
  logic [4:0]  lat_dest, lat_dest_d;
  logic        lat_rw,   lat_rw_d;
  logic        lat_load, lat_load_d;

  logic        dmem_req_d, dmem_we_d;
  logic [31:0] dmem_addr_d, dmem_wdata_d;
  logic [3:0]  dmem_be_d;
  logic        out_valid_d, reg_write_out_d, align_err_d;
  logic [31:0] wb_data_d;
  logic [4:0]  destination_out_d;

  logic        memop;
  logic        misaligned;
  logic [31:0] load_value;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] busy_cnt, busy_cnt_d;
  logic          timeout;
  logic          bus_err_q, bus_err_d;
`endif

  load_align u_load_align (
    .rdata      (dmem_rdata),
    .offset     (lat_off),
    .size       (lat_size),
    .mem_signed (lat_signed),
    .wb_value   (load_value)
  );

  assign memop      = in_valid & (mem_read | mem_write);
  assign misaligned = is_misaligned(mem_size, alu_result[1:0]);

  always_comb begin
    state_d           = state;
    lat_off_d         = lat_off;
    lat_size_d        = lat_size;
    lat_signed_d      = lat_signed;
    lat_dest_d        = lat_dest;
    lat_rw_d          = lat_rw;
    lat_load_d        = lat_load;
    dmem_req_d        = dmem_req;
    dmem_we_d         = dmem_we;
    dmem_addr_d       = dmem_addr;
    dmem_be_d         = dmem_be;
    dmem_wdata_d      = dmem_wdata;
    out_valid_d       = 1'b0;
    align_err_d       = 1'b0;
    wb_data_d         = wb_data;
    destination_out_d = destination_out;
    reg_write_out_d   = reg_write_out;
    stall_out         = 1'b0;
`ifdef MEM_TIMEOUT_EN
    busy_cnt_d        = busy_cnt;
    bus_err_d         = 1'b0;
    // the increment this cycle would reach TIMEOUT_CYCLES; an ack wins
    timeout           = (state == BUSY) && !dmem_ack &&
                        (busy_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

    case (state)
      IDLE: begin
        if (in_valid && !memop) begin
          out_valid_d       = 1'b1;
          wb_data_d         = alu_result;
          destination_out_d = destination;
          reg_write_out_d   = reg_write;
        end else if (memop && misaligned) begin
          out_valid_d       = 1'b1;
          align_err_d       = 1'b1;
          destination_out_d = destination;
          reg_write_out_d   = 1'b0;
        end else if (memop) begin
          stall_out    = 1'b1;
          state_d      = BUSY;
          lat_off_d    = alu_result[1:0];
          lat_size_d   = mem_size;
          lat_signed_d = mem_signed;
          lat_dest_d   = destination;
          lat_rw_d     = reg_write;
          lat_load_d   = mem_read;
          dmem_req_d   = 1'b1;
          dmem_we_d    = mem_write & ~mem_read;
          dmem_addr_d  = {alu_result[31:2], 2'b00};
          dmem_be_d    = byte_enables(mem_size, alu_result[1:0]);
          dmem_wdata_d = store_data(mem_size, PB);
`ifdef MEM_TIMEOUT_EN
          busy_cnt_d   = '0;
`endif
        end
      end

      BUSY: begin
        stall_out = ~dmem_ack;
        if (dmem_ack) begin
          state_d           = IDLE;
          dmem_req_d        = 1'b0;
          out_valid_d       = 1'b1;
          destination_out_d = lat_dest;
          if (lat_load) begin
            wb_data_d       = load_value;
            reg_write_out_d = lat_rw;
          end else begin
            reg_write_out_d = 1'b0;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (timeout) begin
          stall_out         = 1'b0;
          state_d           = IDLE;
          dmem_req_d        = 1'b0;
          out_valid_d       = 1'b1;
          bus_err_d         = 1'b1;
          destination_out_d = lat_dest;
          reg_write_out_d   = 1'b0;
        end else begin
          busy_cnt_d = busy_cnt + 1'b1;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      lat_off         <= '0;
      lat_size        <= '0;
      lat_signed      <= 1'b0;
      lat_dest        <= '0;
      lat_rw          <= 1'b0;
      lat_load        <= 1'b0;
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= '0;
      dmem_be         <= '0;
      dmem_wdata      <= '0;
      out_valid       <= 1'b0;
      align_err       <= 1'b0;
      wb_data         <= '0;
      destination_out <= '0;
      reg_write_out   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      busy_cnt        <= '0;
      bus_err_q       <= 1'b0;
`endif
    end else begin
      state           <= state_d;
      lat_off         <= lat_off_d;
      lat_size        <= lat_size_d;
      lat_signed      <= lat_signed_d;
      lat_dest        <= lat_dest_d;
      lat_rw          <= lat_rw_d;
      lat_load        <= lat_load_d;
      dmem_req        <= dmem_req_d;
      dmem_we         <= dmem_we_d;
      dmem_addr       <= dmem_addr_d;
      dmem_be         <= dmem_be_d;
      dmem_wdata      <= dmem_wdata_d;
      out_valid       <= out_valid_d;
      align_err       <= align_err_d;
      wb_data         <= wb_data_d;
      destination_out <= destination_out_d;
      reg_write_out   <= reg_write_out_d;
`ifdef MEM_TIMEOUT_EN
      busy_cnt        <= busy_cnt_d;
      bus_err_q       <= bus_err_d;
`endif
    end
  end

`ifdef MEM_TIMEOUT_EN
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic        mem_signed = 1'b0, reg_write = 1'b0;
  logic [31:0] alu_result = '0, PB = '0;
  logic [4:0]  destination = '0;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        out_valid, reg_write_out, align_err, bus_err;
  logic [31:0] wb_data;
  logic [4:0]  destination_out;

  logic [31:0] la_rdata = '0;
  logic [1:0]  la_off = '0, la_size = '0;
  logic        la_sg = 1'b0;
  logic [31:0] la_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [31:0] wb;
    logic        chk_wb;
    logic [4:0]  dest;
    logic        rw;
    logic        aerr;
    logic        berr;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  off;
    logic [1:0]  size;
    logic        sg;
    logic [31:0] expv;
  } la_vec_t;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mem_read(mem_read),
    .mem_write(mem_write), .mem_size(mem_size), .mem_signed(mem_signed),
    .reg_write(reg_write), .alu_result(alu_result), .PB(PB),
    .destination(destination), .stall_out(stall_out), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .wb_data(wb_data), .destination_out(destination_out),
    .reg_write_out(reg_write_out), .align_err(align_err), .bus_err(bus_err)
  );

  load_align u_la (
    .rdata(la_rdata), .offset(la_off), .size(la_size), .mem_signed(la_sg),
    .wb_value(la_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] wb, input logic chk_wb, input logic [4:0] dest,
                      input logic rw, input logic aerr, input logic berr);
    exp_t e;
    e.wb = wb; e.chk_wb = chk_wb; e.dest = dest; e.rw = rw; e.aerr = aerr; e.berr = berr;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    chk("out_valid", out_valid, 1);
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    if (e.chk_wb) chk("wb_data", wb_data, e.wb);
    chk("destination_out", destination_out, e.dest);
    chk("reg_write_out", reg_write_out, e.rw);
    chk("align_err", align_err, e.aerr);
    chk("bus_err", bus_err, e.berr);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] pb, input logic [4:0] dst,
                       input logic rw);
    in_valid = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz; mem_signed = sg;
    alu_result = addr; PB = pb; destination = dst; reg_write = rw;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // aligned access acknowledged after wait_cyc BUSY cycles without ack
  task automatic mem_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] pb, input logic [4:0] dst,
                        input logic rw, input int unsigned wait_cyc, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic exp_we, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_wb, input logic exp_rw, input logic chk_wb);
    int unsigned stalls = 0;
    drive(rd, wr, sz, sg, addr, pb, dst, rw);
    #1;
    if (stall_out) stalls++;
    tick();
    chk("dmem_req", dmem_req, 1);
    chk("dmem_addr", dmem_addr, exp_addr);
    chk("dmem_be", dmem_be, exp_be);
    chk("dmem_we", dmem_we, exp_we);
    if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
    for (int unsigned k = 0; k < wait_cyc; k++) begin
      if (stall_out) stalls++;
      tick();
    end
    chk("dmem_req_held", dmem_req, 1);
    chk("dmem_addr_held", dmem_addr, exp_addr);
    dmem_ack = 1'b1;
    dmem_rdata = rdata;
    #1;
    chk("stall_at_ack", stall_out, 0);
    push(exp_wb, chk_wb, dst, exp_rw, 1'b0, 1'b0);
    tick();
    dmem_ack = 1'b0;
    dmem_rdata = 32'hDEAD_BEEF;
    idle_inputs();
    chk("stall_cycles", stalls, wait_cyc + 1);
    chk("dmem_req_drop", dmem_req, 0);
    check_out();
  endtask

  initial begin
    la_vec_t lav[$];
    int unsigned n;
    logic seen, stall_prev;

    // load_align standalone
    lav.push_back('{32'h11F2_3344, 2'd0, 2'b00, 1'b1, 32'h0000_0011});
    lav.push_back('{32'h11F2_3344, 2'd1, 2'b00, 1'b1, 32'hFFFF_FFF2});
    lav.push_back('{32'h11F2_3344, 2'd1, 2'b00, 1'b0, 32'h0000_00F2});
    lav.push_back('{32'h11F2_3344, 2'd3, 2'b00, 1'b1, 32'h0000_0044});
    lav.push_back('{32'h11F2_3344, 2'd2, 2'b01, 1'b1, 32'h0000_3344});
    lav.push_back('{32'h80FF_7F01, 2'd0, 2'b01, 1'b1, 32'hFFFF_80FF});
    lav.push_back('{32'h80FF_7F01, 2'd0, 2'b01, 1'b0, 32'h0000_80FF});
    lav.push_back('{32'h80FF_7F01, 2'd2, 2'b00, 1'b1, 32'h0000_007F});
    lav.push_back('{32'h80FF_7F01, 2'd0, 2'b10, 1'b1, 32'h80FF_7F01});
    foreach (lav[i]) begin
      la_rdata = lav[i].rdata; la_off = lav[i].off; la_size = lav[i].size; la_sg = lav[i].sg;
      #1;
      chk("load_align", la_out, lav[i].expv);
    end

    // reset state
    #1;
    chk("rst_stall", stall_out, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_be", dmem_be, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_dest", destination_out, 0);
    chk("rst_rw", reg_write_out, 0);
    chk("rst_align_err", align_err, 0);
    chk("rst_bus_err", bus_err, 0);
    tick();
    reset = 1'b1;
    tick();

    // ALU op
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 5'd5, 1'b1);
    #1;
    chk("alu_stall", stall_out, 0);
    push(32'h1234_5678, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    idle_inputs();
    check_out();
    chk("alu_no_req", dmem_req, 0);
    tick();
    chk("idle_out_valid", out_valid, 0);
    chk("idle_wb_hold", wb_data, 32'h1234_5678);
    chk("idle_dest_hold", destination_out, 5);

    // signed then unsigned byte load, back to back
    mem_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0, 5'd7, 1'b1, 3, 32'h11F2_3344,
           32'h0000_0100, 4'b0100, 1'b0, 32'h0, 32'hFFFF_FFF2, 1'b1, 1'b1);
    mem_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0, 5'd8, 1'b1, 3, 32'h11F2_3344,
           32'h0000_0100, 4'b0100, 1'b0, 32'h0, 32'h0000_00F2, 1'b1, 1'b1);
    // halfword store
    mem_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0206, 32'hAAAA_BEEF, 5'd3, 1'b1, 1, 32'h0,
           32'h0000_0204, 4'b0011, 1'b1, 32'hBEEF_BEEF, 32'h0, 1'b0, 1'b0);
    // word load
    mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_040C, 32'h0, 5'd10, 1'b1, 0, 32'h80FF_7F01,
           32'h0000_040C, 4'b1111, 1'b0, 32'h0, 32'h80FF_7F01, 1'b1, 1'b1);
    // signed halfword load, upper half
    mem_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'h0, 5'd11, 1'b1, 2, 32'h80FF_7F01,
           32'h0000_0000, 4'b1100, 1'b0, 32'h0, 32'hFFFF_80FF, 1'b1, 1'b1);
    // byte store, lowest lane
    mem_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0003, 32'h1234_5678, 5'd12, 1'b0, 1, 32'h0,
           32'h0000_0000, 4'b0001, 1'b1, 32'h7878_7878, 32'h0, 1'b0, 1'b0);
    // read and write both set: handled as a load with reg_write=0
    mem_op(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0812, 32'h5555_5555, 5'd13, 1'b0, 1, 32'h0000_9900,
           32'h0000_0810, 4'b0010, 1'b0, 32'h0, 32'h0000_0099, 1'b0, 1'b1);

    // misaligned word and halfword
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0302, 32'h0, 5'd14, 1'b1);
    #1;
    chk("mis_word_stall", stall_out, 0);
    push(32'h0, 1'b0, 5'd14, 1'b0, 1'b1, 1'b0);
    tick();
    chk("mis_word_no_req", dmem_req, 0);
    check_out();
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h0, 5'd15, 1'b0);
    #1;
    chk("mis_half_stall", stall_out, 0);
    push(32'h0, 1'b0, 5'd15, 1'b0, 1'b1, 1'b0);
    tick();
    idle_inputs();
    chk("mis_half_no_req", dmem_req, 0);
    check_out();
    tick();
    chk("align_err_pulse", align_err, 0);

    // ack outside BUSY ignored
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("stray_ack_idle", out_valid, 0);
    chk("stray_ack_req", dmem_req, 0);

    // reset in the middle of an access
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 5'd16, 1'b1);
    tick();
    idle_inputs();
    chk("rst_mid_req_on", dmem_req, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_req_async", dmem_req, 0);
    tick();
    reset = 1'b1;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("rst_mid_late_ack", out_valid, 0);
    chk("rst_mid_req_off", dmem_req, 0);

`ifdef MEM_TIMEOUT_EN
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 5'd9, 1'b1);
    tick();
    chk("to_req", dmem_req, 1);
    n = 0; seen = 1'b0; stall_prev = 1'b1;
    for (int k = 0; k < 10 && !seen; k++) begin
      stall_prev = stall_out;
      tick();
      n++;
      if (bus_err) seen = 1'b1;
    end
    idle_inputs();
    chk("to_cycles", n, 4);
    chk("to_stall_release", stall_prev, 0);
    chk("to_req_drop", dmem_req, 0);
    push(32'h0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1);
    check_out();
    tick();
    chk("to_pulse", bus_err, 0);
`else
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 5'd9, 1'b1);
    tick();
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus_err || out_valid) seen = 1'b1;
      tick();
    end
    chk("noto_no_err", seen, 0);
    chk("noto_req", dmem_req, 1);
    chk("noto_stall", stall_out, 1);
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("noto_recover", dmem_req, 0);
`endif

    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
